// File: rtl/udp_tx_framer.sv
// Ethernet II / IPv4 / UDP transmit framer: wraps a streamed payload with preamble, headers,
// zero padding, FCS and inter-frame gap, and emits one byte per transfer to the RMII serializer.
module udp_tx_framer #(
  parameter logic [47:0] FPGA_MAC    = 48'h00_1A_2B_3C_4D_5E,
  parameter logic [31:0] FPGA_IP     = 32'hC0_00_02_92,
  parameter logic [15:0] FPGA_PORT   = 16'd5005,
  parameter int          MAX_PAYLOAD = 1472,
  parameter int          IFG_CYCLES  = 48
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [47:0] dest_mac,
  input  logic [31:0] dest_ip,
  input  logic [15:0] dest_port,
  input  logic [15:0] payload_len,
  output logic        start_err,
  output logic        busy,
  input  logic [7:0]  payload,
  input  logic        payload_valid,
  output logic        payload_ready,
  output logic [7:0]  tx_byte,
  output logic        tx_valid,
  input  logic        tx_ready,
  output logic        tx_last,
  output logic        frame_done
);

  // Handshake: a byte moves on any cycle where valid & ready are both high. Once tx_valid is
  // raised outside PAYLOAD, tx_byte holds until tx_ready; in PAYLOAD the upstream valid is passed
  // straight through, so payload_ready is only ever high together with tx_ready.

  localparam logic [15:0] MAX_LEN  = 16'(MAX_PAYLOAD);
  localparam logic [15:0] IFG_LAST = 16'(IFG_CYCLES - 1);

  typedef enum logic [3:0] {
    S_IDLE, S_CSUM, S_PREAMBLE, S_ETH_HDR, S_IP_HDR,
    S_UDP_HDR, S_PAYLOAD, S_PAD, S_FCS, S_IFG
  } state_t;

  state_t      state, state_nxt;
  logic [15:0] cnt, cnt_nxt;
  logic [47:0] mac_q;
  logic [31:0] ip_q;
  logic [15:0] port_q;
  logic [15:0] len_q;
  logic [15:0] id_q;
  logic [15:0] csum_q;
  logic [31:0] crc_q;
  logic        crc_en;
  logic        id_inc;

  logic [15:0] total_len, udp_len, pad_len;
  logic [31:0] csum_sum, csum_fold1;
  logic [15:0] csum_fold2, csum_calc;

  logic [13:0][7:0] eth_b;
  logic [19:0][7:0] ip_b;
  logic [7:0][7:0]  udp_b;
  logic [3:0][7:0]  fcs_b;

  function automatic logic [31:0] crc32_byte(input logic [31:0] c, input logic [7:0] d);
    logic [31:0] r;
    r = c ^ {24'h0, d};
    for (int i = 0; i < 8; i++) begin
      r = r[0] ? ((r >> 1) ^ 32'hEDB88320) : (r >> 1);
    end
    return r;
  endfunction

  assign total_len = len_q + 16'd28;
  assign udp_len   = len_q + 16'd8;
  assign pad_len   = (len_q < 16'd18) ? (16'd18 - len_q) : 16'd0;

  // Header images, first byte on the wire in the most significant position.
  assign eth_b = {mac_q, FPGA_MAC, 16'h0800};
  assign ip_b  = {16'h4500, total_len, id_q, 16'h4000, 16'h4011, csum_q, FPGA_IP, ip_q};
  assign udp_b = {FPGA_PORT, port_q, udp_len, 16'h0000};
  assign fcs_b = ~crc_q;

  always_comb begin
    csum_sum = 32'h4500 + {16'h0, total_len} + {16'h0, id_q} + 32'h4000 + 32'h4011
             + {16'h0, FPGA_IP[31:16]} + {16'h0, FPGA_IP[15:0]}
             + {16'h0, ip_q[31:16]} + {16'h0, ip_q[15:0]};
    csum_fold1 = {16'h0, csum_sum[15:0]} + {16'h0, csum_sum[31:16]};
    csum_fold2 = csum_fold1[15:0] + csum_fold1[31:16];
    csum_calc  = ~csum_fold2;
  end

  assign busy = (state != S_IDLE);

  always_comb begin
    state_nxt     = state;
    cnt_nxt       = cnt;
    tx_byte       = 8'h00;
    tx_valid      = 1'b0;
    tx_last       = 1'b0;
    payload_ready = 1'b0;
    frame_done    = 1'b0;
    crc_en        = 1'b0;
    id_inc        = 1'b0;
    case (state)
      S_IDLE: begin
        cnt_nxt = 16'd0;
        if (start && (payload_len <= MAX_LEN)) state_nxt = S_CSUM;
      end
      S_CSUM: begin
        state_nxt = S_PREAMBLE;
        cnt_nxt   = 16'd0;
      end
      S_PREAMBLE: begin
        tx_valid = 1'b1;
        tx_byte  = (cnt == 16'd7) ? 8'hD5 : 8'h55;
        if (tx_ready) begin
          cnt_nxt = cnt + 16'd1;
          if (cnt == 16'd7) begin
            state_nxt = S_ETH_HDR;
            cnt_nxt   = 16'd0;
          end
        end
      end
      S_ETH_HDR: begin
        tx_valid = 1'b1;
        tx_byte  = eth_b[4'd13 - cnt[3:0]];
        crc_en   = tx_ready;
        if (tx_ready) begin
          cnt_nxt = cnt + 16'd1;
          if (cnt == 16'd13) begin
            state_nxt = S_IP_HDR;
            cnt_nxt   = 16'd0;
          end
        end
      end
      S_IP_HDR: begin
        tx_valid = 1'b1;
        tx_byte  = ip_b[5'd19 - cnt[4:0]];
        crc_en   = tx_ready;
        if (tx_ready) begin
          cnt_nxt = cnt + 16'd1;
          if (cnt == 16'd19) begin
            state_nxt = S_UDP_HDR;
            cnt_nxt   = 16'd0;
          end
        end
      end
      S_UDP_HDR: begin
        tx_valid = 1'b1;
        tx_byte  = udp_b[3'd7 - cnt[2:0]];
        crc_en   = tx_ready;
        if (tx_ready) begin
          cnt_nxt = cnt + 16'd1;
          if (cnt == 16'd7) begin
            state_nxt = (len_q == 16'd0) ? S_PAD : S_PAYLOAD;
            cnt_nxt   = 16'd0;
          end
        end
      end
      S_PAYLOAD: begin
        tx_valid      = payload_valid;
        tx_byte       = payload;
        payload_ready = payload_valid & tx_ready;
        crc_en        = payload_valid & tx_ready;
        if (payload_valid && tx_ready) begin
          cnt_nxt = cnt + 16'd1;
          if (cnt == len_q - 16'd1) begin
            state_nxt = (pad_len == 16'd0) ? S_FCS : S_PAD;
            cnt_nxt   = 16'd0;
          end
        end
      end
      S_PAD: begin
        tx_valid = 1'b1;
        crc_en   = tx_ready;
        if (tx_ready) begin
          cnt_nxt = cnt + 16'd1;
          if (cnt == pad_len - 16'd1) begin
            state_nxt = S_FCS;
            cnt_nxt   = 16'd0;
          end
        end
      end
      S_FCS: begin
        tx_valid = 1'b1;
        tx_byte  = fcs_b[cnt[1:0]];
        tx_last  = (cnt == 16'd3);
        if (tx_ready) begin
          cnt_nxt = cnt + 16'd1;
          if (cnt == 16'd3) begin
            state_nxt = S_IFG;
            cnt_nxt   = 16'd0;
            id_inc    = 1'b1;
          end
        end
      end
      S_IFG: begin
        cnt_nxt = cnt + 16'd1;
        if (cnt == IFG_LAST) begin
          state_nxt  = S_IDLE;
          cnt_nxt    = 16'd0;
          frame_done = 1'b1;
        end
      end
      default: begin
        state_nxt = S_IDLE;
        cnt_nxt   = 16'd0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= S_IDLE;
      cnt       <= 16'd0;
      start_err <= 1'b0;
      mac_q     <= 48'h0;
      ip_q      <= 32'h0;
      port_q    <= 16'h0;
      len_q     <= 16'h0;
      id_q      <= 16'h0;
      csum_q    <= 16'h0;
      crc_q     <= 32'hFFFF_FFFF;
    end else begin
      state     <= state_nxt;
      cnt       <= cnt_nxt;
      start_err <= (state == S_IDLE) && start && (payload_len > MAX_LEN);
      if (state == S_IDLE && start && (payload_len <= MAX_LEN)) begin
        mac_q  <= dest_mac;
        ip_q   <= dest_ip;
        port_q <= dest_port;
        len_q  <= payload_len;
      end
      // Checksum uses the id of the frame about to go out; CRC restarts for every frame.
      if (state == S_CSUM) begin
        csum_q <= csum_calc;
        crc_q  <= 32'hFFFF_FFFF;
      end else if (crc_en) begin
        crc_q <= crc32_byte(crc_q, tx_byte);
      end
      if (id_inc) id_q <= id_q + 16'd1;
    end
  end

endmodule
